// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core/data-memory bus seen by the load/store unit
// Optional core_misalign_o exists only when LSU_MISALIGN_EXC_EN is defined.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req_i;
  logic              core_we_i;
  logic [2:0]        core_size_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [DATA_W-1:0] core_wd_i;
  logic [DATA_W-1:0] core_rd_o;
  logic              core_stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wd_o;
  logic [DATA_W-1:0] mem_rd_i;
  logic              mem_ready_i;
`ifdef LSU_MISALIGN_EXC_EN
  logic              core_misalign_o;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, core_misalign_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, core_misalign_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
`else
  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
`endif
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory responder: one-cycle stall protocol, byte lanes, load extension
// Optional misaligned-access trap enabled by LSU_MISALIGN_EXC_EN.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  load_store_unit_if.slave  bus
);
  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  logic              stall_q, stall_d;
  logic [1:0]        a;
  logic [2:0]        size;
  logic              req;
  logic              misalign;
  logic              ready_eff;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] load_data;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    addr     = bus.core_addr_i;
    a        = addr[1:0];
    size     = bus.core_size_i;
    req      = bus.core_req_i & ~rst_i;
    misalign = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    case (size)
      SZ_H, SZ_HU: misalign = req & a[0];
      SZ_W:        misalign = req & (a != 2'b00);
      default:     misalign = 1'b0;
    endcase
`endif
    // A trapped access never reaches memory, so it completes as if ready.
    ready_eff = bus.mem_ready_i | misalign;
    stall_d   = req & ~(stall_q & ready_eff);

    rd_byte = bus.mem_rd_i[{a, 3'b000} +: 8];
    rd_half = a[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
    case (size)
      SZ_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      SZ_BU:   load_data = {24'h0, rd_byte};
      SZ_H:    load_data = {{16{rd_half[15]}}, rd_half};
      SZ_HU:   load_data = {16'h0, rd_half};
      SZ_W:    load_data = bus.mem_rd_i;
      default: load_data = '0;
    endcase

    // Unsigned size codes only make sense for loads; a store with them writes nothing.
    case (size)
      SZ_B:    be = 4'b0001 << a;
      SZ_H:    be = 4'b0011 << {a[1], 1'b0};
      SZ_W:    be = 4'b1111;
      SZ_BU:   be = bus.core_we_i ? 4'b0000 : (4'b0001 << a);
      SZ_HU:   be = bus.core_we_i ? 4'b0000 : (4'b0011 << {a[1], 1'b0});
      default: be = 4'b0000;
    endcase

    case (size)
      SZ_B, SZ_BU: bus.mem_wd_o = {4{bus.core_wd_i[7:0]}};
      SZ_H, SZ_HU: bus.mem_wd_o = {2{bus.core_wd_i[15:0]}};
      default:     bus.mem_wd_o = bus.core_wd_i;
    endcase

    bus.core_stall_o = stall_d;
    bus.mem_req_o    = req & ~misalign;
    bus.mem_we_o     = req & ~misalign & bus.core_we_i;
    bus.mem_be_o     = (req & ~misalign) ? be : 4'b0000;
    bus.mem_addr_o   = addr;
    bus.core_rd_o    = (rst_i | misalign) ? '0 : load_data;
`ifdef LSU_MISALIGN_EXC_EN
    bus.core_misalign_o = misalign & ~stall_d;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
// Extra misaligned-trap checks are compiled in when LSU_MISALIGN_EXC_EN is defined.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic req, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wd);
    bus.core_req_i  = req;
    bus.core_we_i   = we;
    bus.core_size_i = size;
    bus.core_addr_i = addr;
    bus.core_wd_i   = wd;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 32'h0000_0102, 32'hAABB_CCDD, 32'h0000_0000, 4'b0100, 32'hDDDD_DDDD, 32'h0000_0000};
    vecs[1]  = '{1'b0, 3'd0, 32'h0000_0003, 32'h0,         32'h80FF_7F01, 4'b1000, 32'h0,         32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 3'd4, 32'h0000_0003, 32'h0,         32'h80FF_7F01, 4'b1000, 32'h0,         32'h0000_0080};
    vecs[3]  = '{1'b0, 3'd1, 32'h0000_0000, 32'h0,         32'h80FF_7F01, 4'b0011, 32'h0,         32'h0000_7F01};
    vecs[4]  = '{1'b0, 3'd5, 32'h0000_0002, 32'h0,         32'h80FF_7F01, 4'b1100, 32'h0,         32'h0000_80FF};
    vecs[5]  = '{1'b1, 3'd1, 32'h0000_0012, 32'h1234_5678, 32'h0000_0000, 4'b1100, 32'h5678_5678, 32'h0000_0000};
    vecs[6]  = '{1'b1, 3'd2, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[7]  = '{1'b0, 3'd2, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 4'b1111, 32'h0,         32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 3'd4, 32'h0000_0001, 32'h0000_0011, 32'h0000_0000, 4'b0000, 32'h1111_1111, 32'h0000_0000};
    vecs[9]  = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 4'b0000, 32'h0,         32'h0000_0000};
    vecs[10] = '{1'b0, 3'd0, 32'h0000_0001, 32'h0,         32'h80FF_7F01, 4'b0010, 32'h0,         32'h0000_007F};

    // Reset held two cycles with a request pending
    set_req(1'b1, 1'b1, 3'd2, 32'h0, 32'hFFFF_FFFF);
    bus.mem_rd_i    = 32'hFFFF_FFFF;
    bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("rst%0d_stall", i), {31'h0, bus.core_stall_o}, 32'h0);
      check($sformatf("rst%0d_mem_req", i), {31'h0, bus.mem_req_o}, 32'h0);
      check($sformatf("rst%0d_mem_we", i), {31'h0, bus.mem_we_o}, 32'h0);
      check($sformatf("rst%0d_rd", i), bus.core_rd_o, 32'h0);
    end
    next_cycle();
    rst = 1'b0;
    bus.core_we_i = 1'b0;
    @(negedge clk);
    check("post_rst_stall1", {31'h0, bus.core_stall_o}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("post_rst_stall2", {31'h0, bus.core_stall_o}, 32'h0);
    check("post_rst_rd", bus.core_rd_o, 32'hFFFF_FFFF);
    next_cycle();
    bus.core_req_i = 1'b0;

    // Table vectors: each a two-cycle access with memory ready
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      set_req(1'b1, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd);
      bus.mem_rd_i    = vecs[i].rd;
      bus.mem_ready_i = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_stall1", i), {31'h0, bus.core_stall_o}, 32'h1);
      check($sformatf("v%0d_be", i), {28'h0, bus.mem_be_o}, {28'h0, vecs[i].exp_be});
      next_cycle();
      @(negedge clk);
      check($sformatf("v%0d_stall2", i), {31'h0, bus.core_stall_o}, 32'h0);
      check($sformatf("v%0d_mem_req", i), {31'h0, bus.mem_req_o}, 32'h1);
      check($sformatf("v%0d_mem_we", i), {31'h0, bus.mem_we_o}, {31'h0, vecs[i].we});
      check($sformatf("v%0d_addr", i), bus.mem_addr_o, vecs[i].addr);
      check($sformatf("v%0d_wd", i), bus.mem_wd_o, vecs[i].exp_wd);
      check($sformatf("v%0d_rd", i), bus.core_rd_o, vecs[i].exp_rd);
      next_cycle();
      bus.core_req_i = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_idle_stall", i), {31'h0, bus.core_stall_o}, 32'h0);
    end

    // Slow memory: ready low for four cycles, completes in the fifth
    next_cycle();
    set_req(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'h0);
    bus.mem_rd_i    = 32'h1234_5678;
    bus.mem_ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("slow_c%0d_stall", c), {31'h0, bus.core_stall_o}, 32'h1);
      next_cycle();
    end
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    check("slow_c4_stall", {31'h0, bus.core_stall_o}, 32'h0);
    check("slow_c4_rd", bus.core_rd_o, 32'h1234_5678);
    next_cycle();
    bus.core_req_i = 1'b0;

    // Back-to-back SW then LW
    next_cycle();
    set_req(1'b1, 1'b1, 3'd2, 32'h0000_0200, 32'h0BAD_CAFE);
    @(negedge clk);
    check("b2b_sw_stall1", {31'h0, bus.core_stall_o}, 32'h1);
    check("b2b_sw_be", {28'h0, bus.mem_be_o}, 32'hF);
    next_cycle();
    @(negedge clk);
    check("b2b_sw_stall2", {31'h0, bus.core_stall_o}, 32'h0);
    check("b2b_sw_we", {31'h0, bus.mem_we_o}, 32'h1);
    next_cycle();
    set_req(1'b1, 1'b0, 3'd2, 32'h0000_0200, 32'h0);
    bus.mem_rd_i = 32'h0BAD_CAFE;
    @(negedge clk);
    check("b2b_lw_stall1", {31'h0, bus.core_stall_o}, 32'h1);
    check("b2b_lw_we", {31'h0, bus.mem_we_o}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("b2b_lw_stall2", {31'h0, bus.core_stall_o}, 32'h0);
    check("b2b_lw_rd", bus.core_rd_o, 32'h0BAD_CAFE);
    next_cycle();
    bus.core_req_i = 1'b0;

    // Request withdrawn mid-wait
    bus.mem_ready_i = 1'b0;
    next_cycle();
    bus.core_req_i = 1'b1;
    @(negedge clk);
    check("drop_stall1", {31'h0, bus.core_stall_o}, 32'h1);
    next_cycle();
    bus.core_req_i = 1'b0;
    @(negedge clk);
    check("drop_stall_off", {31'h0, bus.core_stall_o}, 32'h0);
    next_cycle();
    bus.core_req_i  = 1'b1;
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    check("drop_restall", {31'h0, bus.core_stall_o}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("drop_done", {31'h0, bus.core_stall_o}, 32'h0);
    next_cycle();
    bus.core_req_i = 1'b0;

    // Reset asserted mid-wait
    bus.mem_ready_i = 1'b0;
    next_cycle();
    bus.core_req_i = 1'b1;
    @(negedge clk);
    check("rstw_stall1", {31'h0, bus.core_stall_o}, 32'h1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rstw_in_rst", {31'h0, bus.core_stall_o}, 32'h0);
    next_cycle();
    rst = 1'b0;
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    check("rstw_restall", {31'h0, bus.core_stall_o}, 32'h1);
    next_cycle();
    @(negedge clk);
    check("rstw_done", {31'h0, bus.core_stall_o}, 32'h0);
    next_cycle();
    bus.core_req_i = 1'b0;

`ifdef LSU_MISALIGN_EXC_EN
    // Misaligned LW traps without touching memory, even with memory not ready
    next_cycle();
    set_req(1'b1, 1'b0, 3'd2, 32'h0000_0006, 32'h0);
    bus.mem_rd_i    = 32'hFFFF_FFFF;
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    check("mis_stall1", {31'h0, bus.core_stall_o}, 32'h1);
    check("mis_req1", {31'h0, bus.mem_req_o}, 32'h0);
    check("mis_be1", {28'h0, bus.mem_be_o}, 32'h0);
    check("mis_flag1", {31'h0, bus.core_misalign_o}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("mis_stall2", {31'h0, bus.core_stall_o}, 32'h0);
    check("mis_flag2", {31'h0, bus.core_misalign_o}, 32'h1);
    check("mis_rd2", bus.core_rd_o, 32'h0);
    next_cycle();
    bus.core_req_i  = 1'b0;
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    check("mis_flag_idle", {31'h0, bus.core_misalign_o}, 32'h0);
`else
    // Unaligned LH at a=3 passes through on lanes 3:2
    next_cycle();
    set_req(1'b1, 1'b0, 3'd1, 32'h0000_0003, 32'h0);
    bus.mem_rd_i    = 32'h80FF_7F01;
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    check("ua_stall1", {31'h0, bus.core_stall_o}, 32'h1);
    check("ua_be", {28'h0, bus.mem_be_o}, 32'hC);
    next_cycle();
    @(negedge clk);
    check("ua_stall2", {31'h0, bus.core_stall_o}, 32'h0);
    check("ua_rd", bus.core_rd_o, 32'hFFFF_80FF);
    next_cycle();
    bus.core_req_i = 1'b0;
`endif

    next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Responder end of the core's data-memory interface. Accepts core_req_i/core_we_i/core_size_i/core_addr_i/core_wd_i from the processor core.
- Generates core_stall_o per the system stall protocol: the stall rises in the first cycle of a request and falls exactly one cycle later when memory is ready.
- Drives the word-addressed data memory with byte enables, and returns sign- or zero-extended load data to the core.
- Sits between core and data memory inside the processor system.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed 32; byte-enable width DATA_W/8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- core_req_i  in  1  core memory request
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  0=B, 1=H, 2=W, 4=BU, 5=HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data (low bits significant)
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  hold core PC/pipeline
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  byte address, passed through
- mem_wd_o  out  32  lane-replicated store data
- mem_rd_i  in  32  memory read word
- mem_ready_i  in  1  memory completes the access this cycle

Behaviour:
- State: a single register stall_q (WAIT flag). Reset: stall_q=0.
- Outputs are combinational from stall_q and the inputs. During reset they must read core_stall_o=0, mem_req_o=0, mem_we_o=0, core_rd_o=0.
- core_stall_o = core_req_i & ~(stall_q & mem_ready_i).
- stall_q <= core_stall_o every clock; cleared by rst_i.
- With mem_ready_i tied 1: stall high exactly in the first request cycle and low in the second. This satisfies both the "req implies stall now or last cycle" rule and the "stall falls after exactly one cycle" rule.
- If mem_ready_i is low while stall_q=1, the stall stays high until the first cycle with mem_ready_i=1. The access completes in that cycle.
- mem_req_o = core_req_i; mem_we_o = core_req_i & core_we_i; mem_addr_o = core_addr_i.
- Byte enables, by size, using a = core_addr_i[1:0]:
  - B: 4'b0001 << a
  - H: 4'b0011 << {a[1],1'b0}
  - W: 4'b1111
  - Other size codes on a store: mem_be_o = 0, so no lanes are written.
- Store data, by size:
  - B: {4{wd[7:0]}}
  - H: {2{wd[15:0]}}
  - W: wd
- Load extract, from mem_rd_i and core_addr_i/core_size_i:
  - B/BU: byte lane a, sign- or zero-extended.
  - H/HU: half lane a[1], sign- or zero-extended.
  - W: full word.
  - Illegal size: 0.
- core_rd_o is valid in the completion cycle, i.e. core_stall_o=0 with core_req_i=1.
- The core holds all core_* inputs stable while core_stall_o=1.
- Back-to-back requests: after completion stall_q=0, so a new request in the next cycle stalls again for one cycle.
- core_req_i dropping mid-wait (illegal but possible on flush): stall_o=0 and stall_q clears on the next edge.
- rst_i mid-wait: stall_q=0 on the next edge; no residual stall.
- Unaligned H/W accesses are passed through unmodified: H at a=3 uses lanes 3:2, W ignores a.

Optional Feature:
- Macro: LSU_MISALIGN_EXC_EN.
- When defined, add output core_misalign_o (1 bit). A request is misaligned when it is H/HU with a[0]=1, or W with a!=0.
- For a misaligned request:
  - mem_req_o=0 and mem_be_o=0.
  - core_stall_o follows the normal one-cycle protocol, treating mem_ready as 1.
  - core_misalign_o=1 in the completion cycle only; core_rd_o=0.
- When not defined, the port is absent and misaligned accesses behave as in Behaviour.

Test Plan:
- Reset held 2 cycles with core_req_i=1 -> core_stall_o=0, mem_req_o=0. After release, the first req cycle gives stall=1 and the next gives stall=0 (mem_ready_i=1).
- Store byte: addr=0x0000_0102, wd=0xAABBCCDD, size=0, we=1 -> mem_be_o=4'b0100, mem_wd_o=0xDDDDDDDD, mem_we_o=1.
- Load byte/half: mem_rd_i=0x80FF7F01.
  - LB addr 3 -> 0xFFFFFF80.
  - LBU addr 3 -> 0x00000080.
  - LH addr 0 -> 0x00007F01.
  - LHU addr 2 -> 0x000080FF.
- Slow memory: mem_ready_i=0 for 3 cycles after the req, then 1 -> stall high 4 cycles and low in the 5th; core_rd_o valid in the 5th.
- Back-to-back SW then LW with ready=1 -> stall pattern 1,0,1,0. Memory sees be=4'b1111 for the SW and we=0 for the LW.
- With LSU_MISALIGN_EXC_EN: LW at addr 0x6 -> mem_req_o=0, stall 1 then 0, core_misalign_o=1 in cycle 2 only.
